keccak_pad_stream: RTL and testbench
====================================

KECCAK_PAD_STREAM -- requirements
Module: keccak_pad_stream

Interface
REQ-001 SHALL have parameter RATE_BITS, default 1088, Keccak rate in bits; SHALL be a multiple of IN_W.
REQ-002 SHALL have parameter IN_W, default 64, input word width in bits; SHALL be a multiple of 8.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 mode  input  1  domain select, sampled with the first word of each message: 0 = SHA3 (suffix 0x06), 1 = SHAKE (suffix 0x1F).
REQ-006 in_valid  input  1  input word valid.
REQ-007 in_ready  output  1  block can accept a word.
REQ-008 in_data  input  IN_W  message bytes; byte 0 is in the most significant byte.
REQ-009 in_last  input  1  word is the final word of the message.
REQ-010 in_bytes  input  $clog2(IN_W/8)+1  valid byte count on a last word, range 0..IN_W/8; ignored unless in_last=1.
REQ-011 out_valid  output  1  out_block is valid.
REQ-012 out_ready  input  1  downstream accepts the block.
REQ-013 out_block  output  RATE_BITS  padded rate block; message byte 0 is at [RATE_BITS-1:RATE_BITS-8].
REQ-014 out_last  output  1  block is the final block of the message.

Function
REQ-015 A word transfer SHALL occur when in_valid=1 and in_ready=1; a block transfer SHALL occur when out_valid=1 and out_ready=1.
REQ-016 Word pointer wp SHALL take values 0..RATE_BITS/IN_W-1; each transferred word SHALL be written at word slot wp, counted from the most significant end.
REQ-017 FSM states SHALL be FILL, EMIT and EMIT_PAD.
REQ-018 In FILL: in_ready=1 and out_valid=0.
REQ-019 In FILL, a non-last word that fills the final slot SHALL cause a transition to EMIT with out_last=0 and wp=0.
REQ-020 In FILL, a last word with in_bytes<IN_W/8, or with in_bytes=IN_W/8 and wp not in the final slot, SHALL apply padding in the same block and transition to EMIT with out_last=1.
REQ-021 In FILL, a last word with in_bytes=IN_W/8 in the final slot SHALL transition to EMIT with out_last=0 and set a pad-pending flag.
REQ-022 Padding: the byte at message offset n (total bytes) SHALL be the domain suffix, bytes n+1 .. RATE/8-2 SHALL be 0x00, and byte RATE/8-1 SHALL be OR-ed with 0x80.
REQ-023 When n = RATE/8-1, the final byte SHALL be suffix|0x80 (0x86 for SHA3, 0x9F for SHAKE).
REQ-024 Bytes at or beyond offset n SHALL never carry in_data content; stale slots from earlier blocks SHALL be zero.
REQ-025 In EMIT: out_valid=1 and in_ready=0. On transfer, go to EMIT_PAD if pad-pending is set, otherwise to FILL.
REQ-026 In EMIT_PAD: out_block SHALL be suffix byte, then zeros, then a final byte 0x80, with out_last=1; on transfer, go to FILL.
REQ-027 out_valid SHALL rise in the cycle after the completing word transfer, giving 1-cycle latency.
REQ-028 While out_valid=1, out_block and out_last SHALL be held stable until transfer.
REQ-029 The mode latched at the first word SHALL apply to every block of that message; mode changes mid-message SHALL be ignored.
REQ-030 Throughput: a full-word stream SHALL sustain RATE_BITS/IN_W + 1 cycles per block with out_ready held at 1.

Reset
REQ-031 rst=1 SHALL asynchronously force FILL, wp=0, pad-pending=0, out_valid=0, out_last=0, out_block=0 and the latched mode to 0.
REQ-032 Reset mid-message SHALL discard any partial or unsent block; the next word after reset SHALL start a new message.

Structure
REQ-033 Package keccak_pkg SHALL hold the SHA3/SHAKE suffix constants, the 0x80 final-bit constant, the FSM state enum and a default RATE_BITS.
REQ-034 Padding-mask generation (offset n to byte mask and pad bytes) SHALL be one combinational sub-module, keccak_pad_mask.

Verification (RATE_BITS=1088, IN_W=64)
REQ-035 SHAKE, one word with in_last=1 and in_bytes=0 -> one block 0x1F, 134x00, 0x80, with out_last=1.
REQ-036 SHA3, bytes AA BB CC (in_bytes=3) -> block AA BB CC 06, 131x00, 0x80, with out_last=1.
REQ-037 SHAKE, 135 bytes (17 words, last in_bytes=7) -> one block whose final byte is 0x9F, with out_last=1.
REQ-038 SHAKE, 136 bytes -> data block with out_last=0, then block 1F..80 with out_last=1, with no input accepted in between.
REQ-039 out_ready held low for 5 cycles during EMIT -> out_block stable, in_ready=0, transfer on the 6th cycle.
REQ-040 rst pulsed after 9 words, then 3-byte message -> first block shows only the new 3 bytes and padding, with no residual data.

Source files
------------

// File: rtl/keccak_pkg.sv
// Shared constants and types for the Keccak rate-block padding stream.
// Holds the domain-separation suffixes, the final pad bit and the FSM state encoding.
package keccak_pkg;

    localparam int DEFAULT_RATE_BITS = 1088;
    localparam int DEFAULT_IN_W      = 64;

    localparam logic [7:0] SUFFIX_SHA3  = 8'h06;
    localparam logic [7:0] SUFFIX_SHAKE = 8'h1F;
    localparam logic [7:0] FINAL_BIT    = 8'h80;

    typedef enum logic [1:0] {
        ST_FILL,
        ST_EMIT,
        ST_EMIT_PAD
    } state_t;

    function automatic logic [7:0] suffix_of(input logic mode);
        return mode ? SUFFIX_SHAKE : SUFFIX_SHA3;
    endfunction

endpackage

// File: rtl/keccak_pad_mask.sv
// Combinational pad generator: for message length n (bytes) gives a keep mask for
// bytes below n and the pad pattern (suffix at n, 0x80 OR-ed into the last rate byte).
module keccak_pad_mask
    import keccak_pkg::*;
#(
    parameter int RATE_BITS = DEFAULT_RATE_BITS,
    localparam int RATE_BYTES = RATE_BITS / 8,
    localparam int NW = $clog2(RATE_BYTES + 1)
) (
    input  logic [NW-1:0]        n_i,
    input  logic [7:0]           suffix_i,
    output logic [RATE_BITS-1:0] keep_o,
    output logic [RATE_BITS-1:0] pad_o
);

    // Byte 0 sits at the most significant end of the block.
    for (genvar gi = 0; gi < RATE_BYTES; gi++) begin : g_byte
        localparam logic [NW-1:0] IDX = NW'(gi);
        localparam logic [7:0] TAIL = (gi == RATE_BYTES - 1) ? FINAL_BIT : 8'h00;

        assign keep_o[RATE_BITS-1-8*gi -: 8] = (IDX < n_i) ? 8'hFF : 8'h00;
        assign pad_o[RATE_BITS-1-8*gi -: 8]  = ((IDX == n_i) ? suffix_i : 8'h00) | TAIL;
    end

endmodule

// File: rtl/keccak_pad_stream.sv
// Packs a byte-stream of IN_W-bit words into Keccak rate blocks and applies
// SHA3/SHAKE multi-rate padding, emitting an extra pad-only block when needed.
module keccak_pad_stream
    import keccak_pkg::*;
#(
    parameter int RATE_BITS = DEFAULT_RATE_BITS,
    parameter int IN_W      = DEFAULT_IN_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mode,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [IN_W-1:0]          in_data,
    input  logic                     in_last,
    input  logic [$clog2(IN_W/8):0]  in_bytes,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [RATE_BITS-1:0]     out_block,
    output logic                     out_last
);

    localparam int BPW        = IN_W / 8;
    localparam int WORDS      = RATE_BITS / IN_W;
    localparam int RATE_BYTES = RATE_BITS / 8;
    localparam int NW         = $clog2(RATE_BYTES + 1);
    localparam int WPW        = $clog2(WORDS + 1);
    localparam int IBW        = $clog2(BPW) + 1;

    state_t                 state_q, state_d;
    logic [WPW-1:0]         wp_q, wp_d;
    logic                   pend_q, pend_d;
    logic                   mode_q, mode_d;
    logic                   msg_start_q, msg_start_d;
    logic                   last_q, last_d;
    logic [RATE_BITS-1:0]   block_q, block_d;

    logic [RATE_BITS-1:0]   written;
    logic [RATE_BITS-1:0]   keep_mask;
    logic [RATE_BITS-1:0]   pad_bytes;
    logic [NW-1:0]          n_fill;
    logic [NW-1:0]          pad_n;
    logic [7:0]             suffix;
    logic                   final_slot;
    logic                   full_word;

    assign final_slot = (wp_q == WPW'(WORDS - 1));
    assign full_word  = (in_bytes == IBW'(BPW));
    assign n_fill     = NW'(wp_q) * NW'(BPW) + NW'(in_bytes);

    // In FILL the first word of a message uses the live mode; otherwise the latched one.
    assign pad_n  = (state_q == ST_FILL) ? n_fill : '0;
    assign suffix = suffix_of((state_q == ST_FILL && msg_start_q) ? mode : mode_q);

    keccak_pad_mask #(
        .RATE_BITS (RATE_BITS)
    ) u_pad_mask (
        .n_i      (pad_n),
        .suffix_i (suffix),
        .keep_o   (keep_mask),
        .pad_o    (pad_bytes)
    );

    always_comb begin
        written = block_q;
        for (int i = 0; i < WORDS; i++) begin
            if (wp_q == WPW'(i)) begin
                written[RATE_BITS-1-i*IN_W -: IN_W] = in_data;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        wp_d        = wp_q;
        pend_d      = pend_q;
        mode_d      = mode_q;
        msg_start_d = msg_start_q;
        last_d      = last_q;
        block_d     = block_q;
        in_ready    = (state_q == ST_FILL);
        out_valid   = (state_q != ST_FILL);

        unique case (state_q)
            ST_FILL: begin
                if (in_valid) begin
                    if (msg_start_q) begin
                        mode_d = mode;
                    end
                    msg_start_d = in_last;
                    if (in_last && !(full_word && final_slot)) begin
                        block_d = (written & keep_mask) | pad_bytes;
                        last_d  = 1'b1;
                        wp_d    = '0;
                        state_d = ST_EMIT;
                    end else begin
                        block_d = written;
                        if (final_slot) begin
                            // A full last word in the final slot leaves no room for padding.
                            pend_d  = in_last;
                            last_d  = 1'b0;
                            wp_d    = '0;
                            state_d = ST_EMIT;
                        end else begin
                            wp_d = wp_q + 1'b1;
                        end
                    end
                end
            end
            ST_EMIT: begin
                if (out_ready) begin
                    if (pend_q) begin
                        block_d = pad_bytes;
                        last_d  = 1'b1;
                        pend_d  = 1'b0;
                        state_d = ST_EMIT_PAD;
                    end else begin
                        block_d = '0;
                        last_d  = 1'b0;
                        state_d = ST_FILL;
                    end
                end
            end
            ST_EMIT_PAD: begin
                if (out_ready) begin
                    block_d = '0;
                    last_d  = 1'b0;
                    state_d = ST_FILL;
                end
            end
            default: state_d = ST_FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_FILL;
            wp_q        <= '0;
            pend_q      <= 1'b0;
            mode_q      <= 1'b0;
            msg_start_q <= 1'b1;
            last_q      <= 1'b0;
            block_q     <= '0;
        end else begin
            state_q     <= state_d;
            wp_q        <= wp_d;
            pend_q      <= pend_d;
            mode_q      <= mode_d;
            msg_start_q <= msg_start_d;
            last_q      <= last_d;
            block_q     <= block_d;
        end
    end

    assign out_block = block_q;
    assign out_last  = last_q;

endmodule

// File: tb/tb_keccak_pad_stream.sv
// Directed bench for keccak_pad_stream (RATE_BITS=1088, IN_W=64) with hand-built
// expected blocks; inputs change and outputs are sampled on the falling edge.
module tb_keccak_pad_stream;

    localparam int RB = 1088;
    localparam int W  = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          mode;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          in_last;
    logic [3:0]    in_bytes;
    logic          out_valid;
    logic          out_ready;
    logic [RB-1:0] out_block;
    logic          out_last;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]    msg [0:135];
    logic [RB-1:0] blk;
    logic          lst;

    keccak_pad_stream #(.RATE_BITS(RB), .IN_W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_bytes  (in_bytes),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_block (out_block),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [RB-1:0] got, input logic [RB-1:0] exp);
        int k;
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            k = 0;
            while (k < 135 && got[RB-1-8*k -: 8] === exp[RB-1-8*k -: 8]) k++;
            $display("FAIL %s: byte %0d is %h, expected %h", tag, k,
                     got[RB-1-8*k -: 8], exp[RB-1-8*k -: 8]);
        end
    endtask

    function automatic logic [W-1:0] word_of(input int w);
        logic [W-1:0] r;
        for (int j = 0; j < 8; j++) r[W-1-8*j -: 8] = msg[8*w+j];
        return r;
    endfunction

    // n message bytes from msg[], then (if pad) suffix at n and 0x80 OR-ed into byte 135.
    function automatic logic [RB-1:0] exp_block(input int n, input logic [7:0] sfx, input logic pad);
        logic [RB-1:0] r;
        logic [7:0]    b;
        for (int k = 0; k < 136; k++) begin
            b = (k < n) ? msg[k] : 8'h00;
            if (pad && k == n) b = sfx;
            if (pad && k == 135) b = b | 8'h80;
            r[RB-1-8*k -: 8] = b;
        end
        return r;
    endfunction

    // Called at a falling edge; returns at the falling edge after the transfer.
    task automatic push_word(input logic [W-1:0] d, input logic l, input logic [3:0] nb, input logic md);
        int t;
        t = 0;
        in_data = d; in_last = l; in_bytes = nb; mode = md; in_valid = 1'b1;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("push_ready", RB'(in_ready), RB'(1));
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = '1;
    endtask

    task automatic get_block(output logic [RB-1:0] b, output logic l);
        int t;
        t = 0;
        while (!out_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("out_valid", RB'(out_valid), RB'(1));
        b = out_block;
        l = out_last;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; mode = 1'b0; in_valid = 1'b0; in_data = '0;
        in_last = 1'b0; in_bytes = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", RB'(out_valid), RB'(0));
        chk("rst_out_block", out_block, '0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", RB'(in_ready), RB'(1));
        chk("idle_out_last", RB'(out_last), RB'(0));

        // SHAKE empty message.
        for (int k = 0; k < 136; k++) msg[k] = 8'h00;
        push_word(64'h0123456789ABCDEF, 1'b1, 4'd0, 1'b1);
        chk("empty_latency", RB'(out_valid), RB'(1));
        get_block(blk, lst);
        chk("empty_block", blk, exp_block(0, 8'h1F, 1'b1));
        chk("empty_last", RB'(lst), RB'(1));
        $display("txn shake_empty block[0]=%h last=%0d", blk[RB-1 -: 8], lst);

        // SHA3 AA BB CC with junk in the unused bytes.
        msg[0] = 8'hAA; msg[1] = 8'hBB; msg[2] = 8'hCC;
        push_word(64'hAABBCC_DDEEFF1122, 1'b1, 4'd3, 1'b0);
        get_block(blk, lst);
        chk("sha3_3b_block", blk, exp_block(3, 8'h06, 1'b1));
        chk("sha3_3b_last", RB'(lst), RB'(1));
        $display("txn sha3_3b block[3]=%h last=%0d", blk[RB-1-24 -: 8], lst);

        // SHA3 exactly one full word, padding lands in the next slot.
        for (int k = 0; k < 8; k++) msg[k] = 8'(8'h10 + k);
        push_word(word_of(0), 1'b1, 4'd8, 1'b0);
        get_block(blk, lst);
        chk("sha3_8b_block", blk, exp_block(8, 8'h06, 1'b1));
        $display("txn sha3_8b block[8]=%h last=%0d", blk[RB-1-64 -: 8], lst);

        // SHAKE 135 bytes: suffix and final bit share the last byte.
        for (int k = 0; k < 136; k++) msg[k] = 8'(k + 1);
        msg[135] = 8'h00;
        for (int w = 0; w < 17; w++) begin
            logic [W-1:0] d;
            d = word_of(w);
            if (w == 16) d[7:0] = 8'hEE;
            push_word(d, w == 16, (w == 16) ? 4'd7 : 4'd8, 1'b1);
        end
        get_block(blk, lst);
        chk("shake_135_block", blk, exp_block(135, 8'h1F, 1'b1));
        chk("shake_135_final", RB'(blk[7:0]), RB'(8'h9F));
        chk("shake_135_last", RB'(lst), RB'(1));
        $display("txn shake_135 final=%h last=%0d", blk[7:0], lst);

        // SHAKE 136 bytes; mode toggled after the first word must be ignored.
        for (int k = 0; k < 136; k++) msg[k] = 8'(8'hC0 ^ k);
        for (int w = 0; w < 17; w++) begin
            push_word(word_of(w), w == 16, 4'd8, w == 0);
        end
        get_block(blk, lst);
        chk("shake_136_data", blk, exp_block(136, 8'h1F, 1'b0));
        chk("shake_136_data_last", RB'(lst), RB'(0));
        chk("shake_136_gap_ready", RB'(in_ready), RB'(0));
        $display("txn shake_136_data byte0=%h last=%0d", blk[RB-1 -: 8], lst);
        for (int k = 0; k < 136; k++) msg[k] = 8'h00;
        get_block(blk, lst);
        chk("shake_136_pad", blk, exp_block(0, 8'h1F, 1'b1));
        chk("shake_136_pad_last", RB'(lst), RB'(1));
        $display("txn shake_136_pad byte0=%h last=%0d", blk[RB-1 -: 8], lst);

        // Back-pressure: out_ready low for 5 cycles.
        msg[0] = 8'h5A; msg[1] = 8'hA5;
        push_word(64'h5AA5_0000_0000_0077, 1'b1, 4'd2, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk("stall_block", out_block, exp_block(2, 8'h06, 1'b1));
            chk("stall_in_ready", RB'(in_ready), RB'(0));
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("stall_done", RB'(out_valid), RB'(0));
        $display("txn stall_5 done out_valid=%0d", out_valid);

        // Reset after 9 words, then a fresh 3-byte SHA3 message.
        for (int w = 0; w < 9; w++) push_word(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 4'd8, 1'b1);
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 136; k++) msg[k] = 8'h00;
        msg[0] = 8'h11; msg[1] = 8'h22; msg[2] = 8'h33;
        push_word(64'h112233_9999999999, 1'b1, 4'd3, 1'b0);
        get_block(blk, lst);
        chk("post_rst_block", blk, exp_block(3, 8'h06, 1'b1));
        $display("txn post_reset block[3]=%h last=%0d", blk[RB-1-24 -: 8], lst);

        // Asynchronous reset while a block is being offered.
        push_word(64'h4242_4242_4242_4242, 1'b1, 4'd1, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("async_out_valid", RB'(out_valid), RB'(0));
        chk("async_out_block", out_block, '0);
        chk("async_out_last", RB'(out_last), RB'(0));
        @(negedge clk);
        rst = 1'b0;
        $display("txn async_reset out_valid=%0d", out_valid);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
